branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor that drives the fetch stage's redirect inputs, `branch_taken` and `target_address`.
- Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looks up the current fetch PC every cycle and predicts taken/target.
- Takes branch resolutions from execute: trains the table and issues a corrective redirect plus flush on a mispredict.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- IDX_W, $clog2(ENTRIES), index width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_pc  in  32  PC currently presented by fetch (its instr_addr_o).
- fetch_valid  in  1  fetch_pc is valid this cycle; low during fetch stall.
- branch_taken  out  1  redirect fetch PC to target_address at next edge.
- target_address  out  32  redirect target.
- pred_taken_o  out  1  prediction for fetch_pc, carried down the pipe with the instruction.
- pred_target_o  out  32  predicted target for fetch_pc, carried down the pipe.
- upd_valid  in  1  execute resolved a conditional branch or jal this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual taken target.
- upd_pred_taken  in  1  prediction made for that instruction at fetch.
- upd_pred_target  in  32  predicted target made at fetch.
- flush_o  out  1  mispredict; younger instructions in IF/ID must be squashed.
- stat_lookups  out  32  lookup count (see Optional Feature).
- stat_mispredicts  out  32  mispredict count (see Optional Feature).

Behaviour:
- Storage: flop arrays only, no RAM.
  - Per entry: valid (1), tag (32-IDX_W-2 bits), target (32), ctr (2).
  - Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Reset (rst high at an edge):
  - All valid cleared; all ctr set to 2'b01 (weakly not-taken). Tags/targets don't-care.
  - While rst high, all outputs forced 0.
  - Reset mid-operation discards any update presented in the same cycle.
- Lookup (combinational from table state):
  - hit = valid[idx] & tag match.
  - pred_taken_o = fetch_valid & hit & ctr[idx][1].
  - pred_target_o = target[idx] when hit, else 0.
  - Latency 0: prediction available in the same cycle as fetch_pc; fetch applies it at the next edge.
- Mispredict detect (combinational):
  - mis = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
- Redirect priority:
  - mis=1: branch_taken=1; target_address = upd_taken ? upd_target : upd_pc+4 (32-bit wrap); flush_o=1.
  - else pred_taken_o=1: branch_taken=1; target_address = pred_target_o; flush_o=0.
  - else: branch_taken=0, target_address=0, flush_o=0.
- Update (at clk edge when upd_valid, rst low):
  - Hit on upd_pc:
    - ctr saturating increment if taken, decrement if not. 11 stays 11; 00 stays 00.
    - If taken, target <= upd_target.
  - Miss and taken: allocate; valid=1, tag, target=upd_target, ctr=2'b10. Overwrites any aliasing entry.
  - Miss and not-taken: no change.
- Simultaneous lookup and update on the same index: lookup sees pre-update contents; new state is visible next cycle.
- fetch_valid low: pred_taken_o=0. Mispredict redirect still issued, since it is independent of fetch_valid.
- One update per cycle. Upstream guarantees at most one resolution per cycle.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_lookups increments on each cycle with fetch_valid=1.
  - stat_mispredicts increments on each cycle with mis=1.
  - Both 32-bit, wrap at 2^32-1 to 0, cleared by rst.
- Undefined: both ports tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then fetch_pc=0x40 with fetch_valid=1 -> pred_taken_o=0, branch_taken=0, flush_o=0.
- upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0 -> same cycle branch_taken=1, target_address=0x100, flush_o=1. Next cycle fetch_pc=0x40 -> pred_taken_o=1, target 0x100.
- Entry at 0x40 with ctr=10; resolve not-taken twice with predictions matching the table each time. First -> redirect to 0x44 with flush_o=1; second -> no flush. Then lookup 0x40 -> pred_taken_o=0 (ctr=00). Third not-taken stays 00.
- ENTRIES=16, entry at 0x40 valid; allocate taken branch at 0x80 (same index, different tag) -> lookup 0x40 misses (pred_taken_o=0); lookup 0x80 hits.
- Mispredict at upd_pc=0x200 (actual not-taken) in the same cycle as a taken prediction for fetch_pc=0x40 -> target_address=0x204 (mispredict wins), flush_o=1.
- With BP_STATS_EN: 10 valid fetch cycles and 3 mispredicts -> stat_lookups=10, stat_mispredicts=3. Assert rst mid-run -> both 0 and all predictions not-taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry. Looks up the fetch PC combinationally, trains
// on execute-stage resolutions and issues a corrective redirect plus flush
// on a mispredict. Optional statistics counters are built when the macro
// BP_STATS_EN is defined; otherwise the stat ports are tied to zero.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        branch_taken,
  output logic [31:0] target_address,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        flush_o,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 32 - IDX_W - 2;

  // Table state: control (valid, ctr) is reset, payload (tag, target) is not.
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      target_q, target_d;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             pred_taken_raw;
  logic [31:0]      pred_target_raw;
  logic             mis;

  // Word-offset bits of the PCs carry no information for a 4-byte ISA.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup and mispredict detection; all outputs held low while in reset.
  always_comb begin
    pred_taken_raw  = fetch_valid & f_hit & ctr_q[f_idx][1];
    pred_target_raw = f_hit ? target_q[f_idx] : 32'd0;
    mis = upd_valid & ((upd_taken != upd_pred_taken) |
                       (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
    pred_taken_o   = 1'b0;
    pred_target_o  = 32'd0;
    branch_taken   = 1'b0;
    target_address = 32'd0;
    flush_o        = 1'b0;
    if (!rst) begin
      pred_taken_o  = pred_taken_raw;
      pred_target_o = pred_target_raw;
      if (mis) begin
        // Execute-stage correction outranks any fetch-side prediction.
        branch_taken   = 1'b1;
        target_address = upd_taken ? upd_target : upd_pc + 32'd4;
        flush_o        = 1'b1;
      end else if (pred_taken_raw) begin
        branch_taken   = 1'b1;
        target_address = pred_target_raw;
      end
    end
  end

  // Training: bump the counter on a hit, allocate only on a taken miss.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid) begin
      if (u_hit) begin
        ctr_d[u_idx] = upd_taken ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
        if (upd_taken) target_d[u_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  // Control state: reset clears valids and parks counters at weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Payload state: tag/target are meaningless while the entry is invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, lookups_d, mispred_q, mispred_d;

  // Free-running event counters that wrap naturally at 2^32.
  always_comb begin
    lookups_d = lookups_q + {31'd0, fetch_valid};
    mispred_d = mispred_q + {31'd0, mis};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q <= 32'd0;
      mispred_q <= 32'd0;
    end else begin
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups     = rst ? 32'd0 : lookups_q;
  assign stat_mispredicts = rst ? 32'd0 : mispred_q;
`else
  assign stat_lookups     = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a stimulus process drives one
// cycle at a time and queues the expected outputs from a table-level
// reference model; a monitor pops and compares on the falling edge.
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        branch_taken;
  logic [31:0] target_address;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_o;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .branch_taken(branch_taken), .target_address(target_address),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_o(flush_o),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        bt;
    logic [31:0] ta;
    logic        fl;
    logic [31:0] sl;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];

  // Reference model: one record per table slot, keyed by (pc/4) mod ENTRIES.
  bit          m_vld[ENTRIES];
  logic [31:0] m_tag[ENTRIES];
  logic [31:0] m_tgt[ENTRIES];
  int          m_ctr[ENTRIES];
  logic [31:0] m_look;
  logic [31:0] m_mis;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENTRIES));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (32'd4 * 32'(ENTRIES));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_vld[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_vld[i] = 1'b0;
      m_ctr[i] = 1;
    end
    m_look = 32'd0;
    m_mis  = 32'd0;
  endtask

  // One clock cycle of stimulus: drive, predict, queue, then advance model.
  task automatic cycle(input bit r, input bit fv, input logic [31:0] fpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    exp_t e;
    bit   hit, mis;
    int   i;
    @(posedge clk);
    #1;
    rst = r; fetch_valid = fv; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;

    hit  = m_hit(fpc);
    mis  = uv && ((ut != upt) || (ut && upt && utgt != uptgt));
    e.pt   = fv && hit && (m_ctr[idx_of(fpc)] >= 2);
    e.ptgt = hit ? m_tgt[idx_of(fpc)] : 32'd0;
    if (mis) begin
      e.bt = 1'b1; e.ta = ut ? utgt : upc + 32'd4; e.fl = 1'b1;
    end else if (e.pt) begin
      e.bt = 1'b1; e.ta = e.ptgt; e.fl = 1'b0;
    end else begin
      e.bt = 1'b0; e.ta = 32'd0; e.fl = 1'b0;
    end
`ifdef BP_STATS_EN
    e.sl = m_look; e.sm = m_mis;
`else
    e.sl = 32'd0; e.sm = 32'd0;
`endif
    if (r) begin
      e.pt = 1'b0; e.ptgt = 32'd0; e.bt = 1'b0; e.ta = 32'd0; e.fl = 1'b0;
      e.sl = 32'd0; e.sm = 32'd0;
    end
    q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (fv)  m_look = m_look + 32'd1;
      if (mis) m_mis  = m_mis + 32'd1;
      if (uv) begin
        i = idx_of(upc);
        if (m_hit(upc)) begin
          m_ctr[i] = ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (ut) m_tgt[i] = utgt;
        end else if (ut) begin
          m_vld[i] = 1'b1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt; m_ctr[i] = 2;
        end
      end
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_taken_o",     {31'd0, pred_taken_o}, {31'd0, e.pt});
        chk("pred_target_o",    pred_target_o,         e.ptgt);
        chk("branch_taken",     {31'd0, branch_taken}, {31'd0, e.bt});
        chk("target_address",   target_address,        e.ta);
        chk("flush_o",          {31'd0, flush_o},      {31'd0, e.fl});
        chk("stat_lookups",     stat_lookups,          e.sl);
        chk("stat_mispredicts", stat_mispredicts,      e.sm);
      end
    end
  end

  logic [31:0] pool[8] = '{32'h40, 32'h80, 32'h200, 32'hC0,
                           32'h1040, 32'h44, 32'hFFFF_FFFC, 32'h0};

  initial begin
    logic [31:0] fpc, upc, utgt, uptgt;
    bit          fv, uv, ut, upt, r;
    int          wait_cnt;
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = 32'd0; upd_valid = 1'b0;
    upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
    model_reset();

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
    // Cold lookup, then a taken mispredict allocating 0x40 -> 0x100.
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    // Train down to strongly not-taken and check saturation.
    cycle(0, 0, 0, 1, 32'h40, 0, 0, 1, 32'h100);
    cycle(0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h40, 1, 32'h100, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    // Aliasing allocation at 0x80 while 0x40 is looked up the same cycle.
    cycle(0, 1, 32'h40, 1, 32'h80, 1, 32'h300, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    // Mispredict wins over a taken fetch prediction; fetch_valid low still redirects.
    cycle(0, 1, 32'h80, 1, 32'h200, 0, 0, 1, 32'h500);
    cycle(0, 0, 32'h80, 1, 32'h80, 1, 32'h340, 1, 32'h300);
    cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    // Fall-through address wraps at 2^32.
    cycle(0, 1, 32'h80, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h8);
    // Reset mid-run discards the concurrent update and clears the table.
    cycle(1, 1, 32'h80, 1, 32'h80, 1, 32'h999, 0, 0);
    cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      fv  = ($urandom_range(0, 3) != 0);
      fpc = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : $urandom;
      uv  = $urandom_range(0, 1) == 1;
      upc = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : $urandom;
      ut  = $urandom_range(0, 1) == 1;
      utgt = ($urandom_range(0, 1) == 1) ? 32'h100 * $urandom_range(1, 4) : $urandom;
      if ($urandom_range(0, 9) < 7) begin
        upt   = m_hit(upc) && (m_ctr[idx_of(upc)] >= 2);
        uptgt = m_hit(upc) ? m_tgt[idx_of(upc)] : 32'd0;
      end else begin
        upt   = $urandom_range(0, 1) == 1;
        uptgt = ($urandom_range(0, 1) == 1) ? utgt : $urandom;
      end
      cycle(r, fv, fpc, uv, upc, ut, utgt, upt, uptgt);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
